// File: rtl/fusion_pkg.sv
// Shared definitions for the bit-fusion datapath: operand precision codes,
// product lane modes and helpers that map a precision pair onto a lane layout.
// Used by the fusion unit, the operand packer and the accumulator.
package fusion_pkg;

  localparam logic [1:0] PREC_8 = 2'b10;
  localparam logic [1:0] PREC_4 = 2'b01;
  localparam logic [1:0] PREC_2 = 2'b00;

  typedef enum logic [1:0] {
    MODE1,
    MODE2,
    MODE4,
    MODE_ILLEGAL
  } lane_mode_t;

  // A product word holds one 32-bit lane for 8x8, two 32-bit lanes for 8x4 / 4x8,
  // and four 16-bit lanes for every other legal pairing.
  function automatic lane_mode_t lane_mode(input logic [1:0] cfga, input logic [1:0] cfgb);
    lane_mode_t m;
    if (cfga == 2'b11 || cfgb == 2'b11) begin
      m = MODE_ILLEGAL;
    end else if (cfga == PREC_8 && cfgb == PREC_8) begin
      m = MODE1;
    end else if ((cfga == PREC_8 && cfgb == PREC_4) || (cfga == PREC_4 && cfgb == PREC_8)) begin
      m = MODE2;
    end else begin
      m = MODE4;
    end
    return m;
  endfunction

  function automatic logic [2:0] lane_count(input lane_mode_t mode);
    logic [2:0] n;
    case (mode)
      MODE1:   n = 3'd1;
      MODE2:   n = 3'd2;
      MODE4:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fusion_lane_extract.sv
// Splits a packed 64-bit fusion product word into four accumulator-width lanes.
// Ports:
//   in_data_i  packed product word
//   mode_i     lane layout (fusion_pkg::lane_mode_t encoding)
//   sgn_i      1 = sign-extend lane fields, 0 = zero-extend
//   lane0_o..lane3_o  extended lanes; lanes beyond the lane count are zero
module fusion_lane_extract
  import fusion_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic [63:0]      in_data_i,
  input  logic [1:0]       mode_i,
  input  logic             sgn_i,
  output logic [ACC_W-1:0] lane0_o,
  output logic [ACC_W-1:0] lane1_o,
  output logic [ACC_W-1:0] lane2_o,
  output logic [ACC_W-1:0] lane3_o
);

  function automatic logic [ACC_W-1:0] ext32(input logic [31:0] v, input logic s);
    return s ? ACC_W'($signed(v)) : ACC_W'(v);
  endfunction

  function automatic logic [ACC_W-1:0] ext16(input logic [15:0] v, input logic s);
    return s ? ACC_W'($signed(v)) : ACC_W'(v);
  endfunction

  always_comb begin
    lane0_o = '0;
    lane1_o = '0;
    lane2_o = '0;
    lane3_o = '0;
    case (lane_mode_t'(mode_i))
      MODE1: begin
        lane0_o = ext32(in_data_i[31:0], sgn_i);
      end
      MODE2: begin
        lane0_o = ext32(in_data_i[31:0], sgn_i);
        lane1_o = ext32(in_data_i[63:32], sgn_i);
      end
      MODE4: begin
        lane0_o = ext16(in_data_i[15:0], sgn_i);
        lane1_o = ext16(in_data_i[31:16], sgn_i);
        lane2_o = ext16(in_data_i[47:32], sgn_i);
        lane3_o = ext16(in_data_i[63:48], sgn_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fusion_accumulator.sv
// Accumulates unpacked fusion product lanes over a programmed number of beats,
// then drains one lane total per output handshake.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start, cfga, cfgb, sgn, beats job request and its configuration (sampled in IDLE)
//   in_valid, in_data, in_ready   input beat handshake
//   out_valid, out_ready          output lane handshake
//   out_data, out_lane, out_last  lane total, lane index, final-lane flag
//   busy                          job in progress
//   err                           one-cycle pulse on a rejected start
module fusion_accumulator
  import fusion_pkg::*;
#(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cfga,
  input  logic [1:0]       cfgb,
  input  logic             sgn,
  input  logic [CNT_W-1:0] beats,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain
  } state_t;

  state_t           state_q, state_d;
  lane_mode_t       mode_q, mode_d;
  logic             sgn_q, sgn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             err_q, err_d;
  logic [ACC_W-1:0] acc_q [4];
  logic [ACC_W-1:0] acc_d [4];
  logic [ACC_W-1:0] lane  [4];

  logic start_ok;
  logic in_fire;
  logic out_fire;
  logic lane_last;

  assign start_ok  = start && (lane_mode(cfga, cfgb) != MODE_ILLEGAL) && (beats != '0);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign lane_last = ({1'b0, idx_q} == (lane_count(mode_q) - 3'd1));

  // Extraction uses the latched job configuration, not the live inputs.
  fusion_lane_extract #(
    .ACC_W (ACC_W)
  ) u_extract (
    .in_data_i (in_data),
    .mode_i    (mode_q),
    .sgn_i     (sgn_q),
    .lane0_o   (lane[0]),
    .lane1_o   (lane[1]),
    .lane2_o   (lane[2]),
    .lane3_o   (lane[3])
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StAccum;
      StAccum: if (in_fire && cnt_q == CNT_W'(1)) state_d = StDrain;
      StDrain: if (out_fire && lane_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StDrain);
    busy      = (state_q != StIdle);
    err       = err_q;
    out_data  = out_valid ? acc_q[idx_q] : '0;
    out_lane  = out_valid ? idx_q : 2'd0;
    out_last  = out_valid && lane_last;
  end

  // Datapath next-state
  always_comb begin
    mode_d = mode_q;
    sgn_d  = sgn_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    err_d  = 1'b0;
    acc_d  = acc_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          mode_d = lane_mode(cfga, cfgb);
          sgn_d  = sgn;
          cnt_d  = beats;
          idx_d  = 2'd0;
          for (int k = 0; k < 4; k++) acc_d[k] = '0;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      StAccum: begin
        if (in_fire) begin
          // Unused lanes extract as zero, so adding all four is harmless.
          for (int k = 0; k < 4; k++) acc_d[k] = acc_q[k] + lane[k];
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDrain: begin
        if (out_fire) idx_d = lane_last ? 2'd0 : idx_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE1;
      sgn_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      err_q  <= 1'b0;
      for (int k = 0; k < 4; k++) acc_q[k] <= '0;
    end else begin
      mode_q <= mode_d;
      sgn_q  <= sgn_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
      for (int k = 0; k < 4; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: tb/tb_fusion_accumulator.sv
// Directed bench for fusion_accumulator. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
module tb_fusion_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  cfga;
  logic [1:0]  cfgb;
  logic        sgn;
  logic [15:0] beats;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        busy;
  logic        err;

  int n_checks;
  int n_fail;

  fusion_accumulator #(
    .ACC_W (32),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfga      (cfga),
    .cfgb      (cfgb),
    .sgn       (sgn),
    .beats     (beats),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [1:0] a, input logic [1:0] b, input logic s,
                      input logic [15:0] n);
    start = 1'b1;
    cfga  = a;
    cfgb  = b;
    sgn   = s;
    beats = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [63:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
  endtask

  task automatic take_lane(input string tag, input logic [31:0] d, input logic [1:0] l,
                           input logic last);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(d));
    check({tag, "_lane"}, 64'(out_lane), 64'(l));
    check({tag, "_last"}, 64'(out_last), 64'(last));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int cyc;
    logic v;
    logic r;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    cfga      = 2'b00;
    cfgb      = 2'b00;
    sgn       = 1'b0;
    beats     = 16'd0;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_lane", 64'(out_lane), 64'd0);

    // MODE1 signed: -5 + 7 - 10 = -8
    kick(2'b10, 2'b10, 1'b1, 16'd3);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    feed(64'h0000_0000_FFFF_FFFB);
    feed(64'h0000_0000_0000_0007);
    feed(64'h0000_0000_FFFF_FFF6);
    in_valid = 1'b0;
    take_lane("t1_l0", 32'hFFFF_FFF8, 2'd0, 1'b1);
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_idle_in_ready", 64'(in_ready), 64'd0);
    check("t1_idle_out_valid", 64'(out_valid), 64'd0);

    // MODE2 unsigned; config changed after start must not matter
    kick(2'b10, 2'b01, 1'b0, 16'd2);
    cfga  = 2'b11;
    cfgb  = 2'b00;
    sgn   = 1'b1;
    beats = 16'd7;
    feed({32'd100, 32'd3});
    feed({32'd1, 32'd4});
    in_valid = 1'b0;
    take_lane("t2_l0", 32'd7, 2'd0, 1'b0);
    take_lane("t2_l1", 32'd101, 2'd1, 1'b1);
    check("t2_busy", 64'(busy), 64'd0);

    // MODE4 signed, back-pressure on lane 2
    kick(2'b00, 2'b00, 1'b1, 16'd1);
    feed(64'hFFFF_0002_8000_7FFF);
    in_valid = 1'b0;
    take_lane("t3_l0", 32'd32767, 2'd0, 1'b0);
    take_lane("t3_l1", 32'hFFFF_8000, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_data", 64'(out_data), 64'd2);
      check("t3_hold_lane", 64'(out_lane), 64'd2);
      check("t3_hold_last", 64'(out_last), 64'd0);
      @(negedge clk);
    end
    take_lane("t3_l2", 32'd2, 2'd2, 1'b0);
    take_lane("t3_l3", 32'hFFFF_FFFF, 2'd3, 1'b1);

    // MODE4 unsigned with random input gaps: 5 * 65535 = 327675
    kick(2'b01, 2'b00, 1'b0, 16'd5);
    hs  = 0;
    cyc = 0;
    while (hs < 5 && cyc < 200) begin
      check("t4_no_early_out", 64'(out_valid), 64'd0);
      v        = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      r        = in_ready;
      @(negedge clk);
      if (v && r) hs++;
      cyc++;
    end
    in_valid = 1'b0;
    check("t4_handshakes", 64'(hs), 64'd5);
    for (int k = 0; k < 4; k++) begin
      take_lane("t4_lane", 32'd327675, 2'(k), (k == 3));
    end

    // Rejected starts
    kick(2'b11, 2'b10, 1'b0, 16'd1);
    check("rej_cfg_err", 64'(err), 64'd1);
    check("rej_cfg_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rej_cfg_err_pulse", 64'(err), 64'd0);
    kick(2'b10, 2'b10, 1'b0, 16'd0);
    check("rej_beats_err", 64'(err), 64'd1);
    check("rej_beats_busy", 64'(busy), 64'd0);

    // Start during DRAIN is ignored
    kick(2'b10, 2'b10, 1'b0, 16'd1);
    feed(64'd5);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("drain_start_err", 64'(err), 64'd0);
    check("drain_start_busy", 64'(busy), 64'd1);
    take_lane("drain_l0", 32'd5, 2'd0, 1'b1);
    check("drain_err_after", 64'(err), 64'd0);

    // Reset mid-ACCUM, then a clean job
    kick(2'b10, 2'b10, 1'b0, 16'd4);
    feed(64'd1000);
    feed(64'd1000);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kick(2'b10, 2'b10, 1'b0, 16'd1);
    feed(64'd9);
    in_valid = 1'b0;
    take_lane("arst_l0", 32'd9, 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
